vol_ramp_bank: RTL and testbench
================================

Name: vol_ramp_bank

Overview:
- Sits between the SPI register slave and the AUDIOVOLUME stages. It takes the 32 raw target volumes written over SPI and produces the smoothed volumes that drive every AUDIOVOLUME instance.
- Each current volume moves toward its target by at most STEP per audio frame (LRCLK period). This removes zipper noise when a fader jumps.
- Channels are processed one per clock by a small scan FSM in the MCLK domain.

Parameters:
- NUM_CH, 32, number of volume channels.
- VOL_BIT, 8, width of each volume word.
- STEP, 4, maximum change per frame per channel; valid range 1 to 2^VOL_BIT-1.

Ports:
- CLK  in  1  MCLK-domain clock.
- RST  in  1  synchronous, active-low reset.
- LRCLK  in  1  I2S frame clock; asynchronous to CLK, synchronised internally.
- TGT_VOL  in  NUM_CH*VOL_BIT  packed target volumes from the SPI slave; channel k is at bits [k*VOL_BIT +: VOL_BIT]. Quasi-static, from another clock domain.
- MUTE  in  1  when 1, all targets are treated as 0.
- VOL_OUT  out  NUM_CH*VOL_BIT  packed current (smoothed) volumes, same layout as TGT_VOL.
- SETTLED  out  1  1 when every channel equalled its effective target at the end of the last scan.
- SCAN_BUSY  out  1  1 while the FSM is in SCAN.

Behaviour:
- Reset (RST=0 sampled on a CLK rising edge): all VOL_OUT words = 0, SETTLED=0, SCAN_BUSY=0, FSM=IDLE. The synchroniser and snapshot registers also clear to 0.
  - Reset wins over every other event, including reset during a scan: the scan aborts and VOL_OUT clears on the next cycle.
- LRCLK handling: passed through a 2-FF synchroniser plus one edge-detect register. A rising edge produces a 1-cycle pulse frame_p, 3 CLK after the LRCLK edge.
- Target capture:
  - TGT_VOL is registered twice every cycle, into stage A and then stage B.
  - On frame_p, if A==B, snap <= B. Otherwise snap keeps its previous value, so a torn multi-byte SPI update is never used.
  - Effective target: eff_k = MUTE ? 0 : snap_k. MUTE is sampled each scan cycle.
- FSM states:
  - IDLE: SCAN_BUSY=0. On frame_p: idx <= 0, all_eq <= 1, go to SCAN.
  - SCAN: one channel per cycle, on channel idx:
    - cur < eff: cur <= cur + min(STEP, eff-cur).
    - cur > eff: cur <= cur - min(STEP, cur-eff).
    - cur == eff: unchanged.
    - all_eq <= all_eq & (new cur == eff).
    - If idx==NUM_CH-1, go to DONE; otherwise idx <= idx+1.
  - DONE: SETTLED <= all_eq, go to IDLE. This takes exactly 1 cycle.
- Arithmetic:
  - Differences are computed at VOL_BIT+1 bits. The step is clamped to the difference, so there is never overshoot, wrap-around or oscillation.
  - Example: 0xFE toward 0xFF with STEP=4 gives 0xFF. 0x02 toward 0x00 gives 0x00.
- frame_p while in SCAN or DONE is ignored; no queueing. A scan takes NUM_CH+1 cycles, far below the 256-cycle frame, so this only happens in abnormal clocking.
- VOL_OUT words are registers and each changes only in its own scan slot. Every word changes at most once per frame.
- Latency: channel k updates at CLK edge (LRCLK edge + 3 + k + 1). SETTLED updates at edge (LRCLK edge + 3 + NUM_CH + 1).
- Untouched targets: a channel whose target never changes stays constant and contributes 1 to all_eq.

Test Plan:
- Reset: hold RST=0 with TGT_VOL all 0xFF → VOL_OUT=0, SETTLED=0, SCAN_BUSY=0; after release and no LRCLK edges → VOL_OUT stays 0.
- Ramp up: ch0 target 0x10, others 0, STEP=4 → ch0 reads 0x04, 0x08, 0x0C, 0x10 after frames 1–4; SETTLED=0 after frames 1–3 and 1 after frame 4; SCAN_BUSY high for exactly 32 cycles per frame.
- Non-multiple and down-ramp: ch5 target 0x0A from 0 → 0x04, 0x08, 0x0A; then target 0x01 → 0x06, 0x02, 0x01. Ch31 at 0xFE with target 0xFF → 0xFF in one frame, no wrap.
- Mute: ch3 at 0x40, MUTE=1 → ramps to 0x00 in 16 frames; MUTE=0 → returns to 0x40 in 16 frames.
- Torn update: change TGT_VOL in the cycle before frame_p so that stage A != stage B → that frame uses the previous snapshot; the next frame uses the new value.
- Reset mid-scan: assert RST=0 when idx=10 → all VOL_OUT=0, SCAN_BUSY=0 next cycle. After release, the next frame starts a full scan from channel 0.

Source files
------------

// File: rtl/vol_ramp_bank.sv
// Purpose: slews 32 per-channel volumes toward their SPI targets, at most STEP per LRCLK frame.
// Latency: channel k updates LRCLK edge + 3 + k + 1 clocks; SETTLED at LRCLK edge + 3 + NUM_CH + 1.
// Backpressure: none; a frame pulse arriving while a scan is running is dropped, not queued.
module vol_ramp_bank #(
  parameter int NUM_CH  = 32,
  parameter int VOL_BIT = 8,
  parameter int STEP    = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      LRCLK,
  input  logic [NUM_CH*VOL_BIT-1:0] TGT_VOL,
  input  logic                      MUTE,
  output logic [NUM_CH*VOL_BIT-1:0] VOL_OUT,
  output logic                      SETTLED,
  output logic                      SCAN_BUSY
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [VOL_BIT:0] STEP_W = (VOL_BIT + 1)'(STEP);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic                      lr_s1, lr_s2, lr_d;
  logic                      frame_p;
  logic [NUM_CH*VOL_BIT-1:0] tgt_a, tgt_b, snap_q;
  logic [VOL_BIT-1:0]        snap_w [NUM_CH];
  logic [VOL_BIT-1:0]        cur_q  [NUM_CH];
  logic [1:0]                state;
  logic [IDX_W-1:0]          idx;
  logic                      all_eq;

  logic [VOL_BIT-1:0]        cur_sel, eff_sel;
  logic [VOL_BIT:0]          cur_x, eff_x, diff_up, diff_dn, nxt_x;

  assign frame_p   = lr_s2 & ~lr_d;
  assign SCAN_BUSY = (state == ST_SCAN);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign snap_w[k]                    = snap_q[k*VOL_BIT +: VOL_BIT];
    assign VOL_OUT[k*VOL_BIT +: VOL_BIT] = cur_q[k];
  end

  // Two-flop LRCLK synchroniser plus the edge-detect delay stage.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      lr_s1 <= 1'b0;
      lr_s2 <= 1'b0;
      lr_d  <= 1'b0;
    end else begin
      lr_s1 <= LRCLK;
      lr_s2 <= lr_s1;
      lr_d  <= lr_s2;
    end
  end

  // Double-register the targets; only take a snapshot when both stages agree (no torn SPI write).
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tgt_a  <= '0;
      tgt_b  <= '0;
      snap_q <= '0;
    end else begin
      tgt_a <= TGT_VOL;
      tgt_b <= tgt_a;
      if (frame_p && (tgt_a == tgt_b)) snap_q <= tgt_b;
    end
  end

  assign cur_sel = cur_q[idx];
  assign eff_sel = MUTE ? '0 : snap_w[idx];
  assign cur_x   = {1'b0, cur_sel};
  assign eff_x   = {1'b0, eff_sel};
  assign diff_up = eff_x - cur_x;
  assign diff_dn = cur_x - eff_x;

  // Next value for the scanned channel: step clamped to the remaining distance, so never overshoots.
  always_comb begin
    nxt_x = cur_x;
    if (cur_x < eff_x) begin
      nxt_x = cur_x + ((diff_up < STEP_W) ? diff_up : STEP_W);
    end else if (cur_x > eff_x) begin
      nxt_x = cur_x - ((diff_dn < STEP_W) ? diff_dn : STEP_W);
    end
  end

  // Scan FSM: one channel per clock after each frame pulse, then publish the settled flag.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= ST_IDLE;
      idx     <= '0;
      all_eq  <= 1'b0;
      SETTLED <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) cur_q[k] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_p) begin
            idx    <= '0;
            all_eq <= 1'b1;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          cur_q[idx] <= nxt_x[VOL_BIT-1:0];
          all_eq     <= all_eq & (nxt_x == eff_x);
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          SETTLED <= all_eq;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vol_ramp_bank.sv
// Purpose: self-checking bench for vol_ramp_bank against a per-frame behavioural volume model.
// Latency: checks channel/SETTLED update edges relative to the LRCLK rising edge.
// Backpressure: not applicable; frames are spaced well beyond one scan.
module tb_vol_ramp_bank;

  localparam int NUM_CH = 32;
  localparam int VB     = 8;
  localparam int STEP   = 4;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 LRCLK;
  logic                 MUTE;
  logic [NUM_CH*VB-1:0] TGT_VOL;
  logic [NUM_CH*VB-1:0] VOL_OUT;
  logic                 SETTLED;
  logic                 SCAN_BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_cur  [NUM_CH];
  int m_snap [NUM_CH];
  int m_tgt  [NUM_CH];
  bit m_settled;

  int ch_edge [NUM_CH];
  int set_edge;

  typedef struct {
    int ch;
    int tgt;
    int exp_vol;
    bit exp_set;
  } vec_t;

  vec_t tbl [10];

  vol_ramp_bank #(.NUM_CH(NUM_CH), .VOL_BIT(VB), .STEP(STEP)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LRCLK     (LRCLK),
    .TGT_VOL   (TGT_VOL),
    .MUTE      (MUTE),
    .VOL_OUT   (VOL_OUT),
    .SETTLED   (SETTLED),
    .SCAN_BUSY (SCAN_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [NUM_CH*VB-1:0] act, input logic [NUM_CH*VB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [VB-1:0] word(input logic [NUM_CH*VB-1:0] v, input int k);
    return v[k*VB +: VB];
  endfunction

  task automatic set_tgt(input int k, input int v);
    m_tgt[k] = v;
    TGT_VOL[k*VB +: VB] = VB'(v);
  endtask

  function automatic logic [NUM_CH*VB-1:0] model_vec();
    logic [NUM_CH*VB-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) v[k*VB +: VB] = VB'(m_cur[k]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_cur[k]  = 0;
      m_snap[k] = 0;
    end
    m_settled = 0;
  endfunction

  // One frame: each channel moves toward its effective target by at most STEP.
  function automatic void model_frame(input bit torn, input bit mute);
    int eff;
    if (!torn) for (int k = 0; k < NUM_CH; k++) m_snap[k] = m_tgt[k];
    m_settled = 1;
    for (int k = 0; k < NUM_CH; k++) begin
      eff = mute ? 0 : m_snap[k];
      if (m_cur[k] < eff) m_cur[k] += (eff - m_cur[k] < STEP) ? eff - m_cur[k] : STEP;
      else if (m_cur[k] > eff) m_cur[k] -= (m_cur[k] - eff < STEP) ? m_cur[k] - eff : STEP;
      if (m_cur[k] != eff) m_settled = 0;
    end
  endfunction

  // Raise LRCLK just after edge 0, run 44 clocks, record when each output changed.
  task automatic do_frame(input bit torn, input int tch, input int tval);
    logic [NUM_CH*VB-1:0] prev;
    logic                 prev_set;
    int                   busy;
    model_frame(torn, MUTE);
    for (int k = 0; k < NUM_CH; k++) ch_edge[k] = -1;
    set_edge = -1;
    busy = 0;
    prev = VOL_OUT;
    prev_set = SETTLED;
    @(posedge CLK); #1;
    LRCLK = 1'b1;
    for (int e = 1; e <= 44; e++) begin
      @(posedge CLK); #1;
      if (torn && e == 1) set_tgt(tch, tval);
      if (e == 20) LRCLK = 1'b0;
      if (SCAN_BUSY) busy++;
      for (int k = 0; k < NUM_CH; k++)
        if (word(VOL_OUT, k) !== word(prev, k) && ch_edge[k] < 0) ch_edge[k] = e;
      if (SETTLED !== prev_set && set_edge < 0) set_edge = e;
      prev = VOL_OUT;
      prev_set = SETTLED;
    end
    check("frame_vol", VOL_OUT, model_vec());
    check("frame_settled", {255'b0, SETTLED}, {255'b0, m_settled});
    check("frame_busy_cycles", busy, 32);
  endtask

  initial begin
    tbl[0] = '{0, 'h10, 'h04, 1'b0};
    tbl[1] = '{0, 'h10, 'h08, 1'b0};
    tbl[2] = '{0, 'h10, 'h0C, 1'b0};
    tbl[3] = '{0, 'h10, 'h10, 1'b1};
    tbl[4] = '{5, 'h0A, 'h04, 1'b0};
    tbl[5] = '{5, 'h0A, 'h08, 1'b0};
    tbl[6] = '{5, 'h0A, 'h0A, 1'b1};
    tbl[7] = '{5, 'h01, 'h06, 1'b0};
    tbl[8] = '{5, 'h01, 'h02, 1'b0};
    tbl[9] = '{5, 'h01, 'h01, 1'b1};

    // reset with all targets at full scale
    RST = 1'b0;
    LRCLK = 1'b0;
    MUTE = 1'b0;
    TGT_VOL = '1;
    for (int k = 0; k < NUM_CH; k++) m_tgt[k] = 255;
    model_reset();
    repeat (5) @(posedge CLK);
    #1;
    check("reset_vol", VOL_OUT, '0);
    check("reset_settled", {255'b0, SETTLED}, '0);
    check("reset_busy", {255'b0, SCAN_BUSY}, '0);
    RST = 1'b1;
    repeat (50) @(posedge CLK);
    #1;
    check("idle_no_frame_vol", VOL_OUT, '0);
    check("idle_no_frame_busy", {255'b0, SCAN_BUSY}, '0);
    for (int k = 0; k < NUM_CH; k++) set_tgt(k, 0);
    repeat (5) @(posedge CLK);

    // table: ramp up ch0, then up and down on ch5
    for (int i = 0; i < 10; i++) begin
      set_tgt(tbl[i].ch, tbl[i].tgt);
      repeat (4) @(posedge CLK);
      do_frame(1'b0, 0, 0);
      check($sformatf("tbl%0d_vol", i), word(VOL_OUT, tbl[i].ch), tbl[i].exp_vol);
      check($sformatf("tbl%0d_settled", i), {255'b0, SETTLED}, {255'b0, tbl[i].exp_set});
      if (i == 0) check("ch0_update_edge", ch_edge[0], 4);
      if (i == 3) check("settled_update_edge", set_edge, 36);
    end

    // ch31 up to 0xFE, then one step of 1 to 0xFF with no wrap
    set_tgt(31, 'hFE);
    repeat (64) do_frame(1'b0, 0, 0);
    check("ch31_at_fe", word(VOL_OUT, 31), 'hFE);
    set_tgt(31, 'hFF);
    do_frame(1'b0, 0, 0);
    check("ch31_to_ff", word(VOL_OUT, 31), 'hFF);
    check("ch31_update_edge", ch_edge[31], 35);

    // mute ramps ch3 down from 0x40 and back
    set_tgt(3, 'h40);
    repeat (16) do_frame(1'b0, 0, 0);
    check("ch3_at_40", word(VOL_OUT, 3), 'h40);
    MUTE = 1'b1;
    repeat (15) do_frame(1'b0, 0, 0);
    check("mute_ch3_15", word(VOL_OUT, 3), 'h04);
    do_frame(1'b0, 0, 0);
    check("mute_ch3_16", word(VOL_OUT, 3), 'h00);
    MUTE = 1'b0;
    repeat (15) do_frame(1'b0, 0, 0);
    check("unmute_ch3_15", word(VOL_OUT, 3), 'h3C);
    do_frame(1'b0, 0, 0);
    check("unmute_ch3_16", word(VOL_OUT, 3), 'h40);

    // torn update: target changes just before the snapshot edge
    do_frame(1'b1, 7, 'h08);
    check("torn_ch7_held", word(VOL_OUT, 7), 'h00);
    repeat (4) @(posedge CLK);
    do_frame(1'b0, 0, 0);
    check("torn_ch7_next", word(VOL_OUT, 7), 'h04);

    // randomized small moves around the current values
    for (int r = 0; r < 30; r++) begin
      int nch, ch, v;
      nch = $urandom_range(0, 4);
      for (int j = 0; j < nch; j++) begin
        ch = $urandom_range(0, NUM_CH - 1);
        v = m_cur[ch] + $urandom_range(0, 24) - 12;
        if ($urandom_range(0, 7) == 0) v = $urandom_range(0, 255);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        set_tgt(ch, v);
      end
      MUTE = ($urandom_range(0, 9) == 0);
      repeat (4) @(posedge CLK);
      do_frame(1'b0, 0, 0);
    end
    MUTE = 1'b0;

    // reset in the middle of a scan (idx == 10)
    set_tgt(0, word(VOL_OUT, 0) + 8);
    repeat (4) @(posedge CLK);
    model_frame(1'b0, 1'b0);
    @(posedge CLK); #1;
    LRCLK = 1'b1;
    repeat (13) @(posedge CLK);
    #1;
    check("midscan_busy", {255'b0, SCAN_BUSY}, 1);
    check("midscan_ch0_moved", word(VOL_OUT, 0), VB'(m_cur[0]));
    RST = 1'b0;
    LRCLK = 1'b0;
    @(posedge CLK); #1;
    check("midscan_reset_vol", VOL_OUT, '0);
    check("midscan_reset_busy", {255'b0, SCAN_BUSY}, '0);
    check("midscan_reset_settled", {255'b0, SETTLED}, '0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    do_frame(1'b0, 0, 0);
    check("post_reset_ch0_edge", ch_edge[0], 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
